// File: rtl/rf_exec_seq.sv
// Execute/writeback sequencer that reads two register file operands, computes an ALU or
// shift-add multiply result, and writes it back through the register file write port.
module rf_exec_seq #(
   parameter int W  = 16,
   parameter int AW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          instr_valid,
   output logic          instr_ready,
   input  logic [2:0]    op,
   input  logic [AW-1:0] rd,
   input  logic [AW-1:0] rs_a,
   input  logic [AW-1:0] rs_b,
   output logic [AW-1:0] rd_addr_a,
   output logic [AW-1:0] rd_addr_b,
   input  logic [W-1:0]  d_out_a,
   input  logic [W-1:0]  d_out_b,
   output logic          wr,
   output logic [AW-1:0] wr_addr,
   output logic [W-1:0]  d_in,
   output logic          busy,
   output logic          done,
   output logic          flag_z,
   output logic          flag_c
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_SHL = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_MOV = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_READ = 3'd1,
      S_EXEC = 3'd2,
      S_MUL  = 3'd3,
      S_WB   = 3'd4
   } state_t;

   state_t state;
   state_t state_nxt;

   logic [2:0]      op_q;
   logic [AW-1:0]   rd_q;
   logic [W-1:0]    opa;
   logic [W-1:0]    opb;
   logic [2*W-1:0]  acc;
   logic [CW-1:0]   cnt;
   logic [W-1:0]    result;
   logic            res_c;

   logic [W:0]      alu_wide;
   logic [2*W-1:0]  mul_add;
   logic [2*W-1:0]  acc_sum;
   logic [W-1:0]    result_nxt;
   logic            res_c_nxt;

   logic            instr_ready_nxt;
   logic            busy_nxt;
   logic            wr_nxt;
   logic            done_nxt;
   logic [AW-1:0]   wr_addr_nxt;
   logic [W-1:0]    d_in_nxt;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (instr_valid) begin
               state_nxt = S_READ;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            if (op_q == OP_MUL) begin
               state_nxt = S_MUL;
            end else begin
               state_nxt = S_EXEC;
            end
         end
         S_EXEC: state_nxt = S_WB;
         S_MUL: begin
            if (cnt == CNT_LAST) begin
               state_nxt = S_WB;
            end else begin
               state_nxt = S_MUL;
            end
         end
         S_WB:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Single-cycle ALU; bit W carries the carry, borrow or last bit shifted out
   always_comb begin
      alu_wide = {(W+1){1'b0}};
      case (op_q)
         OP_ADD:  alu_wide = {1'b0, opa} + {1'b0, opb};
         OP_SUB:  alu_wide = {1'b0, opa} - {1'b0, opb};
         OP_AND:  alu_wide = {1'b0, opa & opb};
         OP_OR:   alu_wide = {1'b0, opa | opb};
         OP_XOR:  alu_wide = {1'b0, opa ^ opb};
         OP_SHL:  alu_wide = {1'b0, opa} << opb[CW-1:0];
         OP_MOV:  alu_wide = {1'b0, opa};
         OP_MUL:  alu_wide = {(W+1){1'b0}};
         default: alu_wide = {(W+1){1'b0}};
      endcase
   end

   // One shift-add multiply step, LSB of opB first
   always_comb begin
      mul_add = {(2*W){1'b0}};
      if (opb[cnt]) begin
         mul_add = {{W{1'b0}}, opa} << cnt;
      end else begin
         mul_add = {(2*W){1'b0}};
      end
      acc_sum = acc + mul_add;
   end

   // Result capture at the end of EXEC or the last multiply step
   always_comb begin
      result_nxt = result;
      res_c_nxt  = res_c;
      if (state == S_EXEC) begin
         result_nxt = alu_wide[W-1:0];
         res_c_nxt  = alu_wide[W];
      end else if ((state == S_MUL) && (cnt == CNT_LAST)) begin
         result_nxt = acc_sum[W-1:0];
         res_c_nxt  = |acc_sum[2*W-1:W];
      end else begin
         result_nxt = result;
         res_c_nxt  = res_c;
      end
   end

   // Instruction latch, operand capture, multiply iteration and flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q      <= 3'd0;
         rd_q      <= {AW{1'b0}};
         rd_addr_a <= {AW{1'b0}};
         rd_addr_b <= {AW{1'b0}};
         opa       <= {W{1'b0}};
         opb       <= {W{1'b0}};
         acc       <= {(2*W){1'b0}};
         cnt       <= {CW{1'b0}};
         result    <= {W{1'b0}};
         res_c     <= 1'b0;
         flag_z    <= 1'b0;
         flag_c    <= 1'b0;
      end else begin
         result <= result_nxt;
         res_c  <= res_c_nxt;
         case (state)
            S_IDLE: begin
               if (instr_valid) begin
                  op_q      <= op;
                  rd_q      <= rd;
                  rd_addr_a <= rs_a;
                  rd_addr_b <= rs_b;
               end
            end
            S_READ: begin
               opa <= d_out_a;
               opb <= d_out_b;
               acc <= {(2*W){1'b0}};
               cnt <= {CW{1'b0}};
            end
            S_MUL: begin
               acc <= acc_sum;
               cnt <= cnt + CW'(1);
            end
            S_WB: begin
               flag_z <= (result == {W{1'b0}});
               flag_c <= res_c;
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   // Output decode from the upcoming state so that every output leaves a flop
   always_comb begin
      instr_ready_nxt = 1'b0;
      busy_nxt        = 1'b0;
      wr_nxt          = 1'b0;
      done_nxt        = 1'b0;
      wr_addr_nxt     = {AW{1'b0}};
      d_in_nxt        = {W{1'b0}};
      if (state_nxt == S_IDLE) begin
         instr_ready_nxt = 1'b1;
         busy_nxt        = 1'b0;
      end else begin
         instr_ready_nxt = 1'b0;
         busy_nxt        = 1'b1;
      end
      if (state_nxt == S_WB) begin
         wr_nxt      = 1'b1;
         done_nxt    = 1'b1;
         wr_addr_nxt = rd_q;
         d_in_nxt    = result_nxt;
      end else begin
         wr_nxt      = 1'b0;
         done_nxt    = 1'b0;
         wr_addr_nxt = {AW{1'b0}};
         d_in_nxt    = {W{1'b0}};
      end
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instr_ready <= 1'b1;
         busy        <= 1'b0;
         wr          <= 1'b0;
         done        <= 1'b0;
         wr_addr     <= {AW{1'b0}};
         d_in        <= {W{1'b0}};
      end else begin
         instr_ready <= instr_ready_nxt;
         busy        <= busy_nxt;
         wr          <= wr_nxt;
         done        <= done_nxt;
         wr_addr     <= wr_addr_nxt;
         d_in        <= d_in_nxt;
      end
   end

endmodule
